// File: rtl/basic_nco_core.sv
// -----------------------------------------------------------------------------
// basic_nco_core
//
// Phase-generation front end of the direct-conversion NCO. An ACC_W-bit phase
// accumulator advances by i_tune on every clock-enabled edge. The top
// PHASE_W-1 bits of the accumulator are rounded half-up and sign-extended into a
// signed fixed-point phase in units of pi, range [-1, 1). That phase feeds the
// downstream sine/cosine lookup stage.
//
// Ports
//   clk      in   1              system clock, rising edge
//   reset    in   1              asynchronous, active-low reset
//   ce       in   1              clock enable; all state advances only when high
//   i_tune   in   ACC_W          unsigned tuning word, f_out = i_tune*f_clk/2^ACC_W
//   o_phase  out  PHASE_W        registered phase, signed Q(PHASE_W-PHASE_POINT).PHASE_POINT
//
// Interface timing: there is no valid/ready handshake. o_phase is valid on
// every cycle once reset is released. It updates only on enabled edges, one
// enabled cycle behind the accumulator.
// -----------------------------------------------------------------------------
module basic_nco_core #(
  parameter int ACC_W         = 32,
  parameter int PHASE_W       = 18,
  parameter int PHASE_POINT   = 16,
  parameter int COARSE_ADDR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic [ACC_W-1:0]   i_tune,
  output logic [PHASE_W-1:0] o_phase
);

  // K bits of the accumulator form the two's-complement phase. The extra
  // output bit is only a sign extension, so the output covers exactly [-1, 1).
  localparam int K      = PHASE_W - 1;
  localparam int FINE_W = K - COARSE_ADDR_W;

  // Reject parameter sets that break the fixed-point layout.
  generate
    if (PHASE_POINT != PHASE_W - 2) begin : g_bad_point
      $error("basic_nco_core: PHASE_POINT must equal PHASE_W-2");
    end
    if (COARSE_ADDR_W >= K) begin : g_bad_coarse
      $error("basic_nco_core: COARSE_ADDR_W must be smaller than PHASE_W-1");
    end
    if (ACC_W <= K) begin : g_bad_acc
      $error("basic_nco_core: ACC_W must exceed PHASE_W-1 to leave a rounding bit");
    end
  endgenerate

  logic [ACC_W-1:0]         acc;
  logic [K-1:0]             p;
  logic                     rnd;
  logic [FINE_W:0]          fine_sum;
  logic [COARSE_ADDR_W-1:0] coarse_sum;
  logic [K-1:0]             p_r;

  assign p   = acc[ACC_W-1 -: K];
  // The first bit below the kept field decides round-half-up.
  assign rnd = acc[ACC_W-K-1];

  // The rounding add is split at the LUT-address boundary to shorten the carry
  // chain. The fine carry feeds the coarse add, so the result is bit-identical
  // to one K-bit add. The coarse add drops its carry-out, which wraps the
  // +1 turn produced by rounding back to -1.
  always_comb begin
    fine_sum   = {1'b0, p[FINE_W-1:0]} + (FINE_W+1)'(rnd);
    coarse_sum = p[K-1:FINE_W] + COARSE_ADDR_W'(fine_sum[FINE_W]);
    p_r        = {coarse_sum, fine_sum[FINE_W-1:0]};
  end

  // o_phase is taken from the pre-update accumulator, which gives one enabled
  // cycle of latency. Reset is asynchronous and overrides ce, including an
  // unknown ce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      o_phase <= '0;
    end else if (ce) begin
      acc     <= acc + i_tune;
      o_phase <= {p_r[K-1], p_r};
    end
  end

endmodule

// File: tb/tb_basic_nco_core.sv
module tb_basic_nco_core;

  localparam int ACC_W   = 32;
  localparam int PHASE_W = 18;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               ce = 1'b0;
  logic [ACC_W-1:0]   i_tune = '0;
  logic [PHASE_W-1:0] o_phase;

  always #5 clk = ~clk;

  basic_nco_core #(
    .ACC_W(32), .PHASE_W(18), .PHASE_POINT(16), .COARSE_ADDR_W(9)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .i_tune(i_tune), .o_phase(o_phase)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] exp_q[$];
  int                 checks = 0;
  int                 errors = 0;
  logic [ACC_W-1:0]   model_acc = '0;
  logic [PHASE_W-1:0] model_last = '0;

  task automatic check(input string name, input logic [PHASE_W-1:0] act,
                       input logic [PHASE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h at %0t", name, act, exp, $time);
    end
  endtask

  // The phase in pi is 2*acc_signed/2^32. Scaled by 2^16 this is
  // acc_signed/2^15. Round half up, then fold +1.0 back to -1.0.
  function automatic logic [PHASE_W-1:0] model_phase(input logic [ACC_W-1:0] a);
    longint s;
    longint q;
    s = longint'(a);
    if (s >= 64'sd2147483648) s = s - 64'sd4294967296;
    q = (s + 64'sd16384) >>> 15;
    if (q >= 64'sd65536) q = q - 64'sd131072;
    return q[PHASE_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: applies one cycle of stimulus on the falling edge and pushes the
  // output expected after the following rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic rst_v, input logic ce_v, input logic [ACC_W-1:0] tune_v);
    logic [PHASE_W-1:0] e;
    @(negedge clk);
    reset  = rst_v;
    ce     = ce_v;
    i_tune = tune_v;
    if (rst_v !== 1'b1) begin
      model_acc  = '0;
      model_last = '0;
      e          = '0;
    end else if (ce_v === 1'b1) begin
      e          = model_phase(model_acc);
      model_acc  = model_acc + tune_v;
      model_last = e;
    end else begin
      e = model_last;
    end
    exp_q.push_back(e);
  endtask

  // Resets, then runs enabled edges and compares each with a fixed value.
  task automatic directed(input string name, input logic [ACC_W-1:0] tune,
                          input int n, input logic [PHASE_W-1:0] v0,
                          input logic [PHASE_W-1:0] v1, input logic [PHASE_W-1:0] v2,
                          input logic [PHASE_W-1:0] v3, input logic [PHASE_W-1:0] v4);
    logic [PHASE_W-1:0] vals[5];
    vals = '{v0, v1, v2, v3, v4};
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, tune);
      @(posedge clk);
      #1;
      check($sformatf("%s_edge%0d", name, i + 1), o_phase, vals[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: the output is valid every cycle, so pop one expectation per
  // rising edge whenever the driver has issued one.
  // ---------------------------------------------------------------------------
  initial begin
    logic [PHASE_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", o_phase, e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset held with unknown ce and i_tune.
    for (int i = 0; i < 3; i++) step(1'b0, 1'bx, 'x);
    @(posedge clk);
    #2;
    check("reset_x_inputs", o_phase, '0);
    // Release with ce low: the output must stay at zero.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd1677722);
    @(posedge clk);
    #2;
    check("release_ce_low", o_phase, '0);

    // 100 kHz at 256 MHz: first three edges, then a full wrap on the scoreboard.
    directed("f100k", 32'd1677722, 3, 18'd0, 18'd51, 18'd102, 18'd0, 18'd0);
    for (int i = 0; i < 2600; i++) step(1'b1, 1'b1, 32'd1677722);

    // Quarter-turn sequence.
    directed("quarter", 32'h4000_0000, 5, 18'h00000, 18'h08000, 18'h30000, 18'h38000, 18'h00000);

    // Rounding boundaries.
    directed("round_up",   32'h0000_4000, 2, 18'd0, 18'd1, 18'd0, 18'd0, 18'd0);
    directed("round_down", 32'h0000_3FFF, 2, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0);
    directed("round_wrap", 32'h7FFF_C000, 2, 18'd0, 18'h30000, 18'd0, 18'd0, 18'd0);

    // ce gating in the middle of the quarter-turn sequence.
    directed("gate_pre", 32'h4000_0000, 3, 18'h00000, 18'h08000, 18'h30000, 18'd0, 18'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h4000_0000);
      @(posedge clk);
      #1;
      check("gate_frozen", o_phase, 18'h30000);
    end
    step(1'b1, 1'b1, 32'h4000_0000);
    @(posedge clk);
    #1;
    check("gate_resume1", o_phase, 18'h38000);
    step(1'b1, 1'b1, 32'h4000_0000);
    @(posedge clk);
    #1;
    check("gate_resume2", o_phase, 18'h00000);

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h1234_5678);
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_acc  = '0;
    model_last = '0;
    #1;
    check("async_reset", o_phase, '0);
    directed("after_reset", 32'h4000_0000, 2, 18'h00000, 18'h08000, 18'd0, 18'd0, 18'd0);

    // Random tuning words, random ce, occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), $urandom);
    end

    // Let the monitor drain the queue.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
